// File: rtl/rr_arbiter_amisha.sv
// Four-way round-robin / fixed-priority arbiter with hold-time limit.
// Ports: clk_amisha, reset_amisha (sync, active-high), r_amisha[4:1] requests,
//   mode_amisha (0 = round-robin, 1 = fixed 4>3>2>1), g_amisha[4:1] one-hot grant,
//   y_amisha[2:0] grant index (0 = none), expire_amisha hold-timeout pulse.
module rr_arbiter_amisha #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 3
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic [4:1] r_amisha,
  input  logic       mode_amisha,
  output logic [4:1] g_amisha,
  output logic [2:0] y_amisha,
  output logic       expire_amisha
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [0:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [2:0]        last_grant;
  logic [2:0]        win;
  logic [4:1]        win_g;
  logic              held;

  // Round-robin scans last+1 .. last (wrapping 4->1), so the previous
  // grantee is naturally lowest priority on a timeout re-grant.
  function automatic logic [2:0] pick(
    input logic [4:1] req,
    input logic [2:0] last,
    input logic       fixed
  );
    logic [2:0] w;
    logic [2:0] jj;
    w = 3'd0;
    if (fixed) begin
      for (int i = 1; i <= 4; i++)
        if (req[i]) w = 3'(i);
    end else begin
      for (int k = 4; k >= 1; k--) begin
        jj = 3'((int'(last) + k - 1) % 4 + 1);
        if (req[jj]) w = jj;
      end
    end
    return w;
  endfunction

  always_comb begin
    win   = pick(r_amisha, last_grant, mode_amisha);
    win_g = 4'b0000;
    if (win != 3'd0) win_g = 4'b0001 << (win - 3'd1);
    held  = |(r_amisha & g_amisha);
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state         <= IDLE;
      g_amisha      <= 4'b0000;
      y_amisha      <= 3'd0;
      expire_amisha <= 1'b0;
      hold_cnt      <= '0;
      last_grant    <= 3'd4;
    end else begin
      expire_amisha <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win != 3'd0) begin
            state      <= GRANT;
            g_amisha   <= win_g;
            y_amisha   <= win;
            last_grant <= win;
            hold_cnt   <= '0;
          end
        end
        GRANT: begin
          if (!held) begin
            // Release wins over a coincident timeout: no expire pulse.
            hold_cnt <= '0;
            g_amisha <= win_g;
            y_amisha <= win;
            if (win != 3'd0) begin
              last_grant <= win;
            end else begin
              state <= IDLE;
            end
          end else if (hold_cnt == HOLD_LAST) begin
            expire_amisha <= 1'b1;
            hold_cnt      <= '0;
            g_amisha      <= win_g;
            y_amisha      <= win;
            last_grant    <= win;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_amisha.sv
// Directed bench for rr_arbiter_amisha (MAX_HOLD = 8).
// Hand-computed grant sequences for reset, rotation, release, fixed, timeout.
module tb_rr_arbiter_amisha;

  logic       clk;
  logic       reset;
  logic [4:1] r;
  logic       mode;
  logic [4:1] g;
  logic [2:0] y;
  logic       expire;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter_amisha #(.MAX_HOLD(8), .HOLD_W(3)) dut (
    .clk_amisha   (clk),
    .reset_amisha (reset),
    .r_amisha     (r),
    .mode_amisha  (mode),
    .g_amisha     (g),
    .y_amisha     (y),
    .expire_amisha(expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:1] eg,
                         input logic [2:0] ey, input logic ee);
    chk({tag, ".g"}, 8'(g), 8'(eg));
    chk({tag, ".y"}, 8'(y), 8'(ey));
    chk({tag, ".exp"}, 8'(expire), 8'(ee));
  endtask

  function automatic logic [4:1] oh(input logic [2:0] idx);
    logic [4:1] v;
    v = 4'b0000;
    if (idx != 3'd0) v[idx] = 1'b1;
    return v;
  endfunction

  logic [2:0] ey;

  initial begin
    reset = 1'b1;
    r     = 4'b1111;
    mode  = 1'b0;

    // 1: reset
    step();
    step();
    chk_out("rst", 4'b0000, 3'd0, 1'b0);
    reset = 1'b0;
    step();
    chk_out("first", 4'b0001, 3'd1, 1'b0);

    // 2: rotation 1,2,3,4,1 with 8-cycle tenures
    ey = 3'd1;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 7; i++) begin
        step();
        chk_out("rr_hold", oh(ey), ey, 1'b0);
      end
      step();
      ey = (ey == 3'd4) ? 3'd1 : ey + 3'd1;
      chk_out("rr_switch", oh(ey), ey, 1'b1);
    end

    // 3: release hand-off
    reset = 1'b1;
    r     = 4'b0011;
    step();
    chk_out("rst2", 4'b0000, 3'd0, 1'b0);
    reset = 1'b0;
    step();
    chk_out("rel_g1", 4'b0001, 3'd1, 1'b0);
    step();
    step();
    r = 4'b0010;
    step();
    chk_out("rel_g2", 4'b0010, 3'd2, 1'b0);
    r = 4'b0000;
    step();
    chk_out("rel_idle", 4'b0000, 3'd0, 1'b0);

    // 4: fixed priority
    mode = 1'b1;
    r    = 4'b1011;
    step();
    chk_out("fix_g4", 4'b1000, 3'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_out("fix_hold", 4'b1000, 3'd4, 1'b0);
    end
    step();
    chk_out("fix_expire", 4'b1000, 3'd4, 1'b1);
    r = 4'b0011;
    step();
    chk_out("fix_g2", 4'b0010, 3'd2, 1'b0);
    r = 4'b0000;
    step();
    chk_out("fix_idle", 4'b0000, 3'd0, 1'b0);

    // 5: sole requester timeout, then release coincident with timeout
    mode = 1'b0;
    r    = 4'b0100;
    step();
    chk_out("solo_g3", 4'b0100, 3'd3, 1'b0);
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 7; i++) begin
        step();
        chk_out("solo_hold", 4'b0100, 3'd3, 1'b0);
      end
      step();
      chk_out("solo_expire", 4'b0100, 3'd3, 1'b1);
    end
    for (int i = 0; i < 7; i++) step();
    chk_out("solo_pre", 4'b0100, 3'd3, 1'b0);
    r = 4'b0000;
    step();
    chk_out("rel_timeout", 4'b0000, 3'd0, 1'b0);

    // 6: reset mid-grant
    r = 4'b0100;
    step();
    chk_out("mid_g3", 4'b0100, 3'd3, 1'b0);
    step();
    r     = 4'b1111;
    reset = 1'b1;
    step();
    chk_out("mid_rst", 4'b0000, 3'd0, 1'b0);
    reset = 1'b0;
    step();
    chk_out("mid_first", 4'b0001, 3'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
